vector_chunk_feeder: RTL and testbench

- Upstream stage of vectorXvector: buffers two operand vectors of number_of_equations_per_cluster elements each.
- Streams them as aligned no_of_units-element chunks on first_row_plus_additional / second_row_plus_additional.
- Zero-pads the final partial chunk so the dot-product tree sees exact zeros in unused lanes.
- Adds a valid/ready handshake and a done pulse so the consumer no longer relies on a fixed cycle count.

---
 rtl/vxv_pkg.sv | 22 ++
 rtl/vector_bank.sv | 45 ++++
 rtl/vector_chunk_feeder.sv | 137 +++++++++++++
 tb/tb_vector_chunk_feeder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vxv_pkg.sv
// Shared types and helpers for the vectorXvector chunk feeder.
package vxv_pkg;

  localparam int ELEMENT_WIDTH_DEF = 32;
  localparam int NO_OF_UNITS_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // A one-entry store still needs a one-bit address.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_bank.sv
// One operand vector store: single write port and a zero-filling chunk read mux.
module vector_bank
  import vxv_pkg::*;
#(
  parameter int noe           = 10,
  parameter int element_width = ELEMENT_WIDTH_DEF,
  parameter int no_of_units   = NO_OF_UNITS_DEF,
  parameter int addr_width    = 16,
  localparam int aw           = addr_bits(noe)
) (
  input  logic                               clk,
  input  logic                               wr_en,
  input  logic [aw-1:0]                      wr_addr,
  input  logic [element_width-1:0]           wr_data,
  input  logic [addr_width-1:0]              chunk_sel,
  output logic [element_width*no_of_units-1:0] chunk
);

  logic [element_width-1:0] mem [noe];
  int unsigned              idx;
  logic [aw-1:0]            ia;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A write in the same cycle as the read is forwarded, so a pass started
  // together with a write already sees the new element.
  always_comb begin
    chunk = '0;
    idx   = 0;
    ia    = '0;
    for (int k = 0; k < no_of_units; k++) begin
      idx = int'(chunk_sel) * no_of_units + k;
      ia  = idx[aw-1:0];
      if (idx < noe) begin
        if (wr_en && (wr_addr == ia))
          chunk[element_width*k +: element_width] = wr_data;
        else
          chunk[element_width*k +: element_width] = mem[ia];
      end
    end
  end

endmodule

// File: rtl/vector_chunk_feeder.sv
// Buffers two operand vectors and streams them as zero-padded lane chunks with
// valid/ready and a done pulse. Optional wr_err port: define FEEDER_WR_ERR_EN.
module vector_chunk_feeder
  import vxv_pkg::*;
#(
  parameter int number_of_equations_per_cluster = 10,
  parameter int element_width                   = ELEMENT_WIDTH_DEF,
  parameter int no_of_units                     = NO_OF_UNITS_DEF,
  parameter int addr_width                      = 16,
  localparam int chunk_count = ceil_div(number_of_equations_per_cluster, no_of_units)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wr_en,
  input  logic                                 wr_sel,
  input  logic [addr_width-1:0]                wr_addr,
  input  logic [element_width-1:0]             wr_data,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 chunk_valid,
  input  logic                                 chunk_ready,
  output logic [element_width*no_of_units-1:0] first_row_plus_additional,
  output logic [element_width*no_of_units-1:0] second_row_plus_additional,
  output logic [addr_width-1:0]                chunk_index,
  output logic                                 chunk_last,
  output logic                                 done
`ifdef FEEDER_WR_ERR_EN
  ,
  output logic                                 wr_err
`endif
);

  localparam int bank_aw = addr_bits(number_of_equations_per_cluster);
  localparam logic [addr_width-1:0] noe_a    = addr_width'(number_of_equations_per_cluster);
  localparam logic [addr_width-1:0] last_idx = addr_width'(chunk_count - 1);

  feeder_state_t                        state;
  logic                                 wr_ok;
  logic [addr_width-1:0]                next_index;
  logic [addr_width-1:0]                read_sel;
  logic [element_width*no_of_units-1:0] bank1_chunk;
  logic [element_width*no_of_units-1:0] bank2_chunk;

  assign wr_ok      = wr_en && (state == ST_IDLE) && (wr_addr < noe_a);
  assign next_index = chunk_index + 1'b1;
  // Banks always present the chunk that would be loaded at the next edge.
  assign read_sel   = (state == ST_STREAM) ? next_index : '0;

  vector_bank #(
    .noe          (number_of_equations_per_cluster),
    .element_width(element_width),
    .no_of_units  (no_of_units),
    .addr_width   (addr_width)
  ) u_vector1 (
    .clk      (clk),
    .wr_en    (wr_ok && !wr_sel),
    .wr_addr  (wr_addr[bank_aw-1:0]),
    .wr_data  (wr_data),
    .chunk_sel(read_sel),
    .chunk    (bank1_chunk)
  );

  vector_bank #(
    .noe          (number_of_equations_per_cluster),
    .element_width(element_width),
    .no_of_units  (no_of_units),
    .addr_width   (addr_width)
  ) u_vector2 (
    .clk      (clk),
    .wr_en    (wr_ok && wr_sel),
    .wr_addr  (wr_addr[bank_aw-1:0]),
    .wr_data  (wr_data),
    .chunk_sel(read_sel),
    .chunk    (bank2_chunk)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                      <= ST_IDLE;
      busy                       <= 1'b0;
      chunk_valid                <= 1'b0;
      chunk_last                 <= 1'b0;
      done                       <= 1'b0;
      chunk_index                <= '0;
      first_row_plus_additional  <= '0;
      second_row_plus_additional <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state                      <= ST_STREAM;
            busy                       <= 1'b1;
            chunk_valid                <= 1'b1;
            chunk_index                <= '0;
            chunk_last                 <= (last_idx == '0);
            first_row_plus_additional  <= bank1_chunk;
            second_row_plus_additional <= bank2_chunk;
          end
        end
        ST_STREAM: begin
          if (chunk_ready) begin
            if (chunk_last) begin
              state                      <= ST_DONE;
              busy                       <= 1'b0;
              done                       <= 1'b1;
              chunk_valid                <= 1'b0;
              chunk_last                 <= 1'b0;
              first_row_plus_additional  <= '0;
              second_row_plus_additional <= '0;
            end else begin
              chunk_index                <= next_index;
              chunk_last                 <= (next_index == last_idx);
              first_row_plus_additional  <= bank1_chunk;
              second_row_plus_additional <= bank2_chunk;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FEEDER_WR_ERR_EN
  // A dropped write in the same cycle as an accepted start still flags.
  always_ff @(posedge clk) begin
    if (!reset)
      wr_err <= 1'b0;
    else if (wr_en && !wr_ok)
      wr_err <= 1'b1;
    else if ((state == ST_IDLE) && start)
      wr_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_vector_chunk_feeder.sv
// Directed bench for vector_chunk_feeder: three instances (NOE=10, 16, 3) share one stimulus stream.
module tb_vector_chunk_feeder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_en = 1'b0;
  logic         wr_sel = 1'b0;
  logic [15:0]  wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         start = 1'b0;
  logic         chunk_ready = 1'b1;

  logic         a_busy, a_valid, a_last, a_done;
  logic [255:0] a_row1, a_row2;
  logic [15:0]  a_index;
  logic         b_busy, b_valid, b_last, b_done;
  logic [255:0] b_row1, b_row2;
  logic [15:0]  b_index;
  logic         c_busy, c_valid, c_last, c_done;
  logic [255:0] c_row1, c_row2;
  logic [15:0]  c_index;
`ifdef FEEDER_WR_ERR_EN
  logic         a_wr_err, b_wr_err, c_wr_err;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  vector_chunk_feeder #(.number_of_equations_per_cluster(10)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(a_busy), .chunk_valid(a_valid),
    .chunk_ready(chunk_ready), .first_row_plus_additional(a_row1),
    .second_row_plus_additional(a_row2), .chunk_index(a_index),
    .chunk_last(a_last), .done(a_done)
`ifdef FEEDER_WR_ERR_EN
    , .wr_err(a_wr_err)
`endif
  );

  vector_chunk_feeder #(.number_of_equations_per_cluster(16)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(b_busy), .chunk_valid(b_valid),
    .chunk_ready(chunk_ready), .first_row_plus_additional(b_row1),
    .second_row_plus_additional(b_row2), .chunk_index(b_index),
    .chunk_last(b_last), .done(b_done)
`ifdef FEEDER_WR_ERR_EN
    , .wr_err(b_wr_err)
`endif
  );

  vector_chunk_feeder #(.number_of_equations_per_cluster(3)) dut_c (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(c_busy), .chunk_valid(c_valid),
    .chunk_ready(chunk_ready), .first_row_plus_additional(c_row1),
    .second_row_plus_additional(c_row2), .chunk_index(c_index),
    .chunk_last(c_last), .done(c_done)
`ifdef FEEDER_WR_ERR_EN
    , .wr_err(c_wr_err)
`endif
  );

  // IEEE-754 single encodings of small integers, written out by hand.
  function automatic logic [31:0] fl(input int n);
    case (n)
      1:  return 32'h3F800000;  2:  return 32'h40000000;
      3:  return 32'h40400000;  4:  return 32'h40800000;
      5:  return 32'h40A00000;  6:  return 32'h40C00000;
      7:  return 32'h40E00000;  8:  return 32'h41000000;
      9:  return 32'h41100000;  10: return 32'h41200000;
      11: return 32'h41300000;  12: return 32'h41400000;
      13: return 32'h41500000;  14: return 32'h41600000;
      15: return 32'h41700000;  16: return 32'h41800000;
      18: return 32'h41900000;  20: return 32'h41A00000;
      22: return 32'h41B00000;  24: return 32'h41C00000;
      26: return 32'h41D00000;  28: return 32'h41E00000;
      30: return 32'h41F00000;  32: return 32'h42000000;
      default: return 32'h0;
    endcase
  endfunction

  // Expected chunk: lane k = element ch*8+k scaled by mult, zero past noe.
  function automatic logic [255:0] exp_bus(input int mult, input int noe, input int ch);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (ch * 8 + k < noe) r[32*k +: 32] = fl(mult * (ch * 8 + k + 1));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_last", a_last, 0);
    check("rst_done", a_done, 0);
    check("rst_index", a_index, 0);
    check("rst_row1", a_row1, 0);
    check("rst_row2", a_row2, 0);
    reset = 1'b1;
    tick();

    // Load v1[i]=i+1, v2[i]=2(i+1); v1[9] is held back for the start cycle.
    for (int i = 0; i < 16; i++) begin
      if (i != 9) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 16'(i); wr_data = fl(i + 1);
        tick();
      end
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 16'(i); wr_data = fl(2 * (i + 1));
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Pass 1: start with a same-cycle write of v1[9], ready held high.
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 16'd9; wr_data = fl(10);
    tick();
    start = 1'b0; wr_en = 1'b0;
    check("p1_c0_valid", a_valid, 1);
    check("p1_c0_busy", a_busy, 1);
    check("p1_c0_index", a_index, 0);
    check("p1_c0_last", a_last, 0);
    check("p1_c0_row1", a_row1, exp_bus(1, 10, 0));
    check("p1_c0_row2", a_row2, exp_bus(2, 10, 0));
    check("b_c0_row1", b_row1, exp_bus(1, 16, 0));
    check("b_c0_last", b_last, 0);
    check("c_c0_last", c_last, 1);
    check("c_c0_row1", c_row1, {160'h0, 32'h40400000, 32'h40000000, 32'h3F800000});
    check("c_c0_row2", c_row2, exp_bus(2, 3, 0));
`ifdef FEEDER_WR_ERR_EN
    check("p1_wr_err_cleared", a_wr_err, 0);
`endif
    tick();
    check("p1_c1_index", a_index, 1);
    check("p1_c1_last", a_last, 1);
    check("p1_c1_row1", a_row1, {192'h0, 32'h41200000, 32'h41100000});
    check("p1_c1_row2", a_row2, {192'h0, 32'h41A00000, 32'h41900000});
    check("b_c1_row1", b_row1, exp_bus(1, 16, 1));
    check("b_c1_row2", b_row2, exp_bus(2, 16, 1));
    check("b_c1_last", b_last, 1);
    check("c_done", c_done, 1);
    check("c_done_valid", c_valid, 0);
    check("c_done_row1", c_row1, 0);
    tick();
    check("p1_done", a_done, 1);
    check("p1_done_busy", a_busy, 0);
    check("p1_done_valid", a_valid, 0);
    check("p1_done_row1", a_row1, 0);
    check("b_done_no_zero_chunk", b_done, 1);
    check("b_done_valid", b_valid, 0);
    tick();
    check("p1_done_pulse_end", a_done, 0);

    // Pass 2: backpressure on chunk 0 with ignored start/write pulses.
    chunk_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (t == 1) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 16'd0; wr_data = 32'hDEADBEEF;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      check("bp_index", a_index, 0);
      check("bp_row1", a_row1, exp_bus(1, 10, 0));
      check("bp_valid", a_valid, 1);
      tick();
    end
    start = 1'b0; wr_en = 1'b0;
    chunk_ready = 1'b1;
    tick();
    check("bp_c1_index", a_index, 1);
    check("bp_c1_row2", a_row2, exp_bus(2, 10, 1));
    tick();
    check("bp_done", a_done, 1);
`ifdef FEEDER_WR_ERR_EN
    check("bp_wr_err_set", a_wr_err, 1);
`endif
    tick();

    // Pass 3: data unchanged by the dropped write; reset mid chunk 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p3_c0_row1", a_row1, exp_bus(1, 10, 0));
`ifdef FEEDER_WR_ERR_EN
    check("p3_wr_err_cleared", a_wr_err, 0);
`endif
    tick();
    check("p3_c1_index", a_index, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_valid", a_valid, 0);
    check("abort_busy", a_busy, 0);
    check("abort_row1", a_row1, 0);
    check("abort_row2", a_row2, 0);
    check("abort_done", a_done, 0);
    check("abort_index", a_index, 0);
    tick();
    check("abort_no_done", a_done, 0);

    // Out-of-range write while idle.
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 16'd10; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
`ifdef FEEDER_WR_ERR_EN
    check("oob_wr_err", a_wr_err, 1);
`endif

    // Replay from retained banks.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rp_c0_row1", a_row1, exp_bus(1, 10, 0));
    check("rp_c0_row2", a_row2, exp_bus(2, 10, 0));
    tick();
    check("rp_c1_row1", a_row1, exp_bus(1, 10, 1));
    check("rp_c1_row2", a_row2, exp_bus(2, 10, 1));
    tick();
    check("rp_done", a_done, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
